drain_to_mem: RTL and testbench
===============================

// Module: drain_to_mem
// PURPOSE
//  Return path of the FIFO-array datapath: pops one DATA_WIDTH entry from each of NUM_FIFOS
//  FIFOs in index order, packs the entries little-endian into MEM_WIDTH words and writes them
//  to memory from a base address. Single-shot per drain request. Sits between the result FIFOs
//  and the memory write port.
// PARAMETERS
//  NUM_FIFOS       9    number of source FIFOs (one entry popped from each per drain)
//  DATA_WIDTH      8    FIFO entry width in bits
//  MEM_WIDTH       64   memory data width; must be an integer multiple of DATA_WIDTH
//  TIMEOUT_CYCLES  255  empty-stall limit per FIFO (DRAIN_TIMEOUT_EN builds only)
// PORTS
//  clk              in   1                     system clock, all logic on rising edge
//  rst              in   1                     synchronous reset, active-high
//  addr             in   32                    destination byte address; bits [2:0] forced to 0
//  drain            in   1                     start request, sampled only in IDLE
//  busy             out  1                     high in every non-IDLE state
//  done             out  1                     1-cycle pulse when the final write is accepted
//  err              out  1                     sticky timeout flag; constant 0 without macro
//  fifoEmpty        in   NUM_FIFOS             per-FIFO empty flags
//  fifoRdEn         out  NUM_FIFOS             one-hot read enable, at most one bit high per cycle
//  fifoData         in   NUM_FIFOS*DATA_WIDTH  flattened read data; FIFO i at [i*DATA_WIDTH +: DATA_WIDTH]
//  mem_address      out  32                    byte address of current write
//  mem_write        out  1                     write request
//  mem_writedata    out  MEM_WIDTH             packed word
//  mem_waitrequest  in   1                     memory stall; the write is held while high
// BEHAVIOUR
//  - Reset: state=IDLE. busy, done, err, fifoRdEn, mem_write, mem_writedata and mem_address = 0.
//    Reset mid-operation aborts immediately. No memory write and no FIFO pop occurs in the cycle
//    after rst is sampled.
//  - FIFO read latency is 1: fifoData[i] is valid the cycle after fifoRdEn[i].
//  - All outputs are Moore-decoded from registered state.
//  - SLOTS = MEM_WIDTH/DATA_WIDTH. Registers: idx (FIFO index), slot, pack buffer, address.
//  - IDLE: on drain, latch {addr[31:3],3'b0}, set idx=0, slot=0, clear buffer, go to POP.
//    drain while busy is ignored.
//  - POP: if fifoEmpty[idx]=0, assert fifoRdEn[idx] and go to LATCH. Otherwise stay in POP
//    with no read enable.
//  - LATCH: buffer[slot*DATA_WIDTH +: DATA_WIDTH] <= fifoData[idx]; idx++, slot++.
//    If slot==SLOTS-1 or idx==NUM_FIFOS-1, go to WRITE; else go to POP.
//  - WRITE: mem_write=1 with a stable address and data until mem_waitrequest=0 is sampled.
//    On accept: address += MEM_WIDTH/8, buffer cleared, slot=0. If all FIFOs are consumed,
//    go to DONE; else go to POP.
//  - DONE: done=1 for one cycle, then go to IDLE.
//  - Partial final word: unused upper slots are zero. Defaults give word0 = FIFOs 0..7 and
//    word1 = FIFO 8 in bits[7:0], zeros above.
//  - Timing without stalls: 2 cycles per entry plus 1 per word write. The address wraps
//    modulo 2^32.
// CONFIGURATION
//  DRAIN_TIMEOUT_EN defined: a counter runs while in POP with fifoEmpty[idx]=1 and resets
//  on any pop. On reaching TIMEOUT_CYCLES: err<=1 (sticky until the next accepted drain or rst),
//  abort with no further pops or writes, go to DONE (done still pulses).
//  DRAIN_TIMEOUT_EN undefined: POP waits indefinitely and err is tied 0.
// STRUCTURE
//  - drain_pkg: state enum {IDLE,POP,LATCH,WRITE,DONE}, WORD_BYTES localparam,
//    aligned-address helper function.
//  - Sub-module drain_word_packer: slot-indexed buffer with clear and write-slot ports,
//    instanced once. The FSM, counters and memory handshake stay in drain_to_mem.
// TESTING
//  1. Defaults, FIFO i holds 8'h10+i, addr=0x100, waitrequest=0, drain pulse -> writes
//     0x100=64'h17161514_13121110 and 0x108=64'h18; done after 21 cycles; fifoRdEn always one-hot.
//  2. waitrequest held high for 5 cycles on the first write -> mem_address and mem_writedata
//     stable throughout, exactly one accepted write per word.
//  3. fifoEmpty[3]=1 for 10 cycles -> no read enables during the stall, no memory write;
//     resumes with FIFO 3 and produces the same data as scenario 1.
//  4. addr=0x10F -> first write at 0x108; addr=0xFFFF_FFF8 -> second write at 0x0000_0000.
//  5. rst asserted during WRITE -> the next cycle has mem_write=0, busy=0 and no further pops;
//     a subsequent drain runs cleanly.
//  6. DRAIN_TIMEOUT_EN, TIMEOUT_CYCLES=4, fifoEmpty[0] stuck high -> err=1 and a done pulse,
//     zero memory writes; err clears on the next accepted drain.

Source files
------------

// File: rtl/drain_pkg.sv
// Shared types and helpers for the FIFO-array drain path.
package drain_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      POP   = 3'd1,
      LATCH = 3'd2,
      WRITE = 3'd3,
      DONE  = 3'd4
   } drain_state_t;

   localparam int unsigned WORD_BYTES = 8;

   // Memory words are 8-byte aligned; the low address bits are dropped.
   function automatic logic [31:0] align_addr(input logic [31:0] a);
      return {a[31:3], 3'b000};
   endfunction

endpackage

// File: rtl/drain_word_packer.sv
// Slot-indexed pack buffer: entries land little-endian at slot*DATA_WIDTH; clear zeroes all slots.
module drain_word_packer #(
   parameter int DATA_WIDTH = 8,
   parameter int SLOTS      = 8,
   parameter int SLOT_W     = 3
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        i_clr,
   input  logic                        i_wr,
   input  logic [SLOT_W-1:0]           i_slot,
   input  logic [DATA_WIDTH-1:0]       i_data,
   output logic [SLOTS*DATA_WIDTH-1:0] o_word
);

   logic [SLOTS*DATA_WIDTH-1:0] r_buf;

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_buf <= '0;
      end else if (i_wr) begin
         r_buf[i_slot*DATA_WIDTH +: DATA_WIDTH] <= i_data;
      end
   end

   assign o_word = r_buf;

endmodule

// File: rtl/drain_to_mem.sv
// Pops one entry per FIFO in index order, packs them into memory words and writes them from a base address.
// Define DRAIN_TIMEOUT_EN to abort a drain whose current FIFO stays empty for TIMEOUT_CYCLES.
module drain_to_mem
   import drain_pkg::*;
#(
   parameter int NUM_FIFOS      = 9,
   parameter int DATA_WIDTH     = 8,
   parameter int MEM_WIDTH      = 64,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [31:0]                     addr,
   input  logic                            drain,
   output logic                            busy,
   output logic                            done,
   output logic                            err,
   input  logic [NUM_FIFOS-1:0]            fifoEmpty,
   output logic [NUM_FIFOS-1:0]            fifoRdEn,
   input  logic [NUM_FIFOS*DATA_WIDTH-1:0] fifoData,
   output logic [31:0]                     mem_address,
   output logic                            mem_write,
   output logic [MEM_WIDTH-1:0]            mem_writedata,
   input  logic                            mem_waitrequest
);

   localparam int SLOTS  = MEM_WIDTH / DATA_WIDTH;
   localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
   localparam int IDX_W  = $clog2(NUM_FIFOS + 1);
   localparam logic [31:0]       ADDR_STEP = 32'(MEM_WIDTH / 8);
   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS - 1);
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_FIFOS - 1);
   localparam logic [IDX_W-1:0]  ALL_IDX   = IDX_W'(NUM_FIFOS);

   drain_state_t          r_state, w_state_nxt;
   logic [IDX_W-1:0]      r_idx;
   logic [SLOT_W-1:0]     r_slot;
   logic [31:0]           r_addr;
   logic                  w_start, w_pop, w_latch, w_accept, w_timeout;
   logic [MEM_WIDTH-1:0]  w_word;

   assign w_start  = (r_state == IDLE) && drain;
   assign w_pop    = (r_state == POP) && !fifoEmpty[r_idx];
   assign w_latch  = (r_state == LATCH);
   assign w_accept = (r_state == WRITE) && !mem_waitrequest;

`ifdef DRAIN_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMO_W-1:0] r_tmo_cnt;
   logic             r_err;
   logic             w_stall;

   assign w_stall   = (r_state == POP) && fifoEmpty[r_idx];
   assign w_timeout = w_stall && (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

   // Counts consecutive empty cycles on the current FIFO; err stays set until the next drain starts.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tmo_cnt <= '0;
         r_err     <= 1'b0;
      end else begin
         r_tmo_cnt <= w_stall ? r_tmo_cnt + 1'b1 : '0;
         if (w_timeout) begin
            r_err <= 1'b1;
         end else if (w_start) begin
            r_err <= 1'b0;
         end
      end
   end

   assign err = r_err;
`else
   assign w_timeout = 1'b0;
   assign err       = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      fifoRdEn    = '0;
      case (r_state)
         IDLE: begin
            if (drain) w_state_nxt = POP;
         end
         POP: begin
            if (w_timeout) begin
               w_state_nxt = DONE;
            end else if (!fifoEmpty[r_idx]) begin
               fifoRdEn[r_idx] = 1'b1;
               w_state_nxt     = LATCH;
            end
         end
         LATCH: begin
            // Flush when the word is full or the last FIFO has just been read.
            if ((r_slot == LAST_SLOT) || (r_idx == LAST_IDX)) begin
               w_state_nxt = WRITE;
            end else begin
               w_state_nxt = POP;
            end
         end
         WRITE: begin
            if (!mem_waitrequest) begin
               w_state_nxt = (r_idx == ALL_IDX) ? DONE : POP;
            end
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_idx  <= '0;
         r_slot <= '0;
         r_addr <= '0;
      end else begin
         if (w_start) begin
            r_idx  <= '0;
            r_slot <= '0;
            r_addr <= align_addr(addr);
         end
         if (w_latch) begin
            r_idx  <= r_idx + 1'b1;
            r_slot <= r_slot + 1'b1;
         end
         if (w_accept) begin
            r_slot <= '0;
            r_addr <= r_addr + ADDR_STEP;
         end
      end
   end

   drain_word_packer #(
      .DATA_WIDTH (DATA_WIDTH),
      .SLOTS      (SLOTS),
      .SLOT_W     (SLOT_W)
   ) u_packer (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (w_start || w_accept),
      .i_wr   (w_latch),
      .i_slot (r_slot),
      .i_data (fifoData[r_idx*DATA_WIDTH +: DATA_WIDTH]),
      .o_word (w_word)
   );

   assign busy          = (r_state != IDLE);
   assign done          = (r_state == DONE);
   assign mem_write     = (r_state == WRITE);
   assign mem_address   = r_addr;
   assign mem_writedata = w_word;

endmodule

// File: tb/tb_drain_to_mem.sv
// Directed bench for drain_to_mem: FIFO and memory models, a word-level expectation queue and per-cycle protocol checks.
module tb_drain_to_mem;

   localparam int NF  = 9;
   localparam int DW  = 8;
   localparam int MW  = 64;
   localparam int TMO = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [31:0]     addr;
   logic            drain;
   logic            busy, done, err;
   logic [NF-1:0]   fifoEmpty;
   logic [NF-1:0]   fifoRdEn;
   logic [NF*DW-1:0] fifoData;
   logic [31:0]     mem_address;
   logic            mem_write;
   logic [MW-1:0]   mem_writedata;
   logic            mem_waitrequest;

   always #5 clk = ~clk;

   drain_to_mem #(
      .NUM_FIFOS      (NF),
      .DATA_WIDTH     (DW),
      .MEM_WIDTH      (MW),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .addr            (addr),
      .drain           (drain),
      .busy            (busy),
      .done            (done),
      .err             (err),
      .fifoEmpty       (fifoEmpty),
      .fifoRdEn        (fifoRdEn),
      .fifoData        (fifoData),
      .mem_address     (mem_address),
      .mem_write       (mem_write),
      .mem_writedata   (mem_writedata),
      .mem_waitrequest (mem_waitrequest)
   );

   int n_cmp = 0;
   int n_bad = 0;

   function automatic void check(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // FIFO model: each FIFO holds one entry per drain; data appears the cycle after its read enable.
   logic [DW-1:0]   fifo_val  [NF];
   logic [DW-1:0]   fifo_dout [NF] = '{default: 8'hEE};
   int              pop_gen   [NF] = '{default: 0};
   int              fill_gen  = 0;
   logic [NF-1:0]   stall_mask;

   always_comb begin
      for (int i = 0; i < NF; i++) begin
         fifoEmpty[i]          = (pop_gen[i] == fill_gen) || stall_mask[i];
         fifoData[i*DW +: DW]  = fifo_dout[i];
      end
   end

   always @(posedge clk) begin
      for (int i = 0; i < NF; i++) begin
         if (fifoRdEn[i] === 1'b1) begin
            check("pop_nonempty", 96'(fifoEmpty[i]), 96'd0);
            pop_gen[i]   <= fill_gen;
            fifo_dout[i] <= fifo_val[i];
         end else begin
            fifo_dout[i] <= 8'hEE;
         end
      end
   end

   // Expected writes for one drain: entry k lands in word k/8, byte k%8; unused bytes are zero.
   logic [95:0] exp_q[$];
   int          drain_gen = 0;
   int          seen_gen  = 0;
   logic [31:0] drain_base;
   int          exp_pop;
   int          n_wr;
   logic [31:0] cap_addr [4];
   logic [63:0] cap_data [4];

   function automatic void expect_drain(input logic [31:0] base);
      logic [31:0] a;
      logic [63:0] d;
      int          k;
      a = {base[31:3], 3'b000};
      exp_q.delete();
      for (int w = 0; w < (NF*DW + MW - 1) / MW; w++) begin
         d = '0;
         for (int j = 0; j < MW / DW; j++) begin
            k = w * (MW / DW) + j;
            if (k < NF) d[j*DW +: DW] = fifo_val[k];
         end
         exp_q.push_back({a + 32'(w * (MW / 8)), d});
      end
   endfunction

   logic        prev_hold = 1'b0;
   logic        prev_done = 1'b0;
   logic [31:0] prev_addr;
   logic [63:0] prev_data;

   always @(negedge clk) begin
      logic [95:0] e;
      if (drain_gen != seen_gen) begin
         seen_gen = drain_gen;
         exp_pop  = 0;
         n_wr     = 0;
         expect_drain(drain_base);
      end
      if (rst) begin
         prev_hold = 1'b0;
         prev_done = 1'b0;
      end else begin
         check("rden_onehot0", 96'($onehot0(fifoRdEn)), 96'd1);
`ifndef DRAIN_TIMEOUT_EN
         check("err_tied_low", 96'(err), 96'd0);
`endif
         if (fifoRdEn != '0) begin
            check("pop_order", 96'(fifoRdEn), 96'(1) << exp_pop);
            exp_pop++;
         end
         if (prev_hold) begin
            check("hold_write", 96'(mem_write), 96'd1);
            check("hold_addr", 96'(mem_address), 96'(prev_addr));
            check("hold_data", 96'(mem_writedata), 96'(prev_data));
         end
         if (mem_write && !mem_waitrequest) begin
            if (exp_q.size() == 0) begin
               check("unexpected_write", 96'd1, 96'd0);
            end else begin
               e = exp_q.pop_front();
               check("wr_addr", 96'(mem_address), 96'(e[95:64]));
               check("wr_data", 96'(mem_writedata), 96'(e[63:0]));
            end
            if (n_wr < 4) begin
               cap_addr[n_wr] = mem_address;
               cap_data[n_wr] = mem_writedata;
            end
            n_wr++;
         end
         if (done) check("done_single_cycle", 96'(prev_done), 96'd0);
         prev_hold = mem_write && mem_waitrequest;
         prev_addr = mem_address;
         prev_data = mem_writedata;
         prev_done = done;
      end
   end

   task automatic fill_fifos(input logic [7:0] start, input logic [7:0] step);
      for (int i = 0; i < NF; i++) fifo_val[i] = 8'(start + 8'(i) * step);
   endtask

   // One drain request; waits up to a bounded number of cycles for done.
   task automatic run_drain(input logic [31:0] base, input int exp_cycles, input int wait_first,
                            input int stall_fifo, input int stall_from, input int stall_len,
                            input bit expect_abort);
      int got;
      int wait_left;
      @(posedge clk); #1;
      fill_gen++;
      drain_base = base;
      drain_gen++;
      addr       = base;
      drain      = 1'b1;
      got        = -1;
      wait_left  = wait_first;
      for (int cyc = 1; cyc <= 400; cyc++) begin
         @(posedge clk); #1;
         drain = 1'b0;
         if (stall_fifo >= 0 && cyc >= stall_from && cyc < stall_from + stall_len)
            stall_mask = NF'(1) << stall_fifo;
         else
            stall_mask = '0;
         if (mem_write && wait_left > 0) begin
            mem_waitrequest = 1'b1;
            wait_left--;
         end else begin
            mem_waitrequest = 1'b0;
         end
         @(negedge clk);
         if (cyc == 1) check("err_clear_on_start", 96'(err), 96'd0);
         check("busy_while_active", 96'(busy), 96'd1);
         if (done) begin
            got = cyc;
            break;
         end
      end
      stall_mask      = '0;
      mem_waitrequest = 1'b0;
      check("done_seen", 96'(got > 0), 96'd1);
      if (exp_cycles > 0) check("done_latency", 96'(got), 96'(exp_cycles));
      check("err_at_done", 96'(err), 96'(expect_abort));
      if (expect_abort) begin
         check("abort_no_writes", 96'(n_wr), 96'd0);
      end else begin
         check("word_count", 96'(n_wr), 96'd2);
         check("all_words_written", 96'(exp_q.size()), 96'd0);
      end
      @(negedge clk);
      check("idle_after_done", 96'(busy), 96'd0);
   endtask

   initial begin
      rst             = 1'b1;
      drain           = 1'b0;
      addr            = '0;
      mem_waitrequest = 1'b0;
      stall_mask      = '0;
      fill_fifos(8'h10, 8'h01);
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 96'(busy), 96'd0);
      check("rst_done", 96'(done), 96'd0);
      check("rst_err", 96'(err), 96'd0);
      check("rst_rden", 96'(fifoRdEn), 96'd0);
      check("rst_mem_write", 96'(mem_write), 96'd0);
      check("rst_mem_addr", 96'(mem_address), 96'd0);
      check("rst_mem_data", 96'(mem_writedata), 96'd0);
      rst = 1'b0;

      // Baseline drain with hand-computed words.
      fill_fifos(8'h10, 8'h01);
      run_drain(32'h100, 21, 0, -1, 0, 0, 1'b0);
      check("s1_addr0", 96'(cap_addr[0]), 96'h100);
      check("s1_data0", 96'(cap_data[0]), 96'h1716151413121110);
      check("s1_addr1", 96'(cap_addr[1]), 96'h108);
      check("s1_data1", 96'(cap_data[1]), 96'h18);

      // Memory stall on the first word.
      fill_fifos(8'h10, 8'h01);
      run_drain(32'h200, 26, 5, -1, 0, 0, 1'b0);
      check("s2_addr0", 96'(cap_addr[0]), 96'h200);
      check("s2_data0", 96'(cap_data[0]), 96'h1716151413121110);

      // FIFO 3 empty for 10 cycles around its turn.
      fill_fifos(8'h10, 8'h01);
      run_drain(32'h100, 30, 0, 3, 6, 10, 1'b0);
      check("s3_data0", 96'(cap_data[0]), 96'h1716151413121110);
      check("s3_data1", 96'(cap_data[1]), 96'h18);

      // Unaligned base and address wrap.
      fill_fifos(8'hC3, 8'h11);
      run_drain(32'h10F, 21, 0, -1, 0, 0, 1'b0);
      check("s4_addr0", 96'(cap_addr[0]), 96'h108);
      check("s4_addr1", 96'(cap_addr[1]), 96'h110);
      check("s4_data1", 96'(cap_data[1]), 96'h4B);
      fill_fifos(8'h81, 8'h05);
      run_drain(32'hFFFF_FFF8, 21, 0, -1, 0, 0, 1'b0);
      check("s4_wrap_addr0", 96'(cap_addr[0]), 96'hFFFF_FFF8);
      check("s4_wrap_addr1", 96'(cap_addr[1]), 96'h0);

      // Reset while a write is pending.
      fill_fifos(8'h10, 8'h01);
      @(posedge clk); #1;
      fill_gen++;
      drain_base = 32'h300;
      drain_gen++;
      addr  = 32'h300;
      drain = 1'b1;
      begin
         bit reached;
         reached = 1'b0;
         for (int cyc = 1; cyc <= 100; cyc++) begin
            @(posedge clk); #1;
            drain = 1'b0;
            if (mem_write) begin
               reached = 1'b1;
               break;
            end
         end
         check("s5_reached_write", 96'(reached), 96'd1);
      end
      mem_waitrequest = 1'b1;
      rst             = 1'b1;
      @(posedge clk); #1;
      check("s5_mem_write", 96'(mem_write), 96'd0);
      check("s5_busy", 96'(busy), 96'd0);
      check("s5_rden", 96'(fifoRdEn), 96'd0);
      check("s5_mem_addr", 96'(mem_address), 96'd0);
      rst             = 1'b0;
      mem_waitrequest = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("s5_quiet_rden", 96'(fifoRdEn), 96'd0);
         check("s5_quiet_write", 96'(mem_write), 96'd0);
      end
      fill_fifos(8'h10, 8'h01);
      run_drain(32'h100, 21, 0, -1, 0, 0, 1'b0);
      check("s5_after_data0", 96'(cap_data[0]), 96'h1716151413121110);

`ifdef DRAIN_TIMEOUT_EN
      // FIFO 0 never fills: four empty cycles then abort.
      fill_fifos(8'h10, 8'h01);
      run_drain(32'h400, 5, 0, 0, 1, 1000, 1'b1);
      check("s6_err_sticky", 96'(err), 96'd1);
      fill_fifos(8'h10, 8'h01);
      run_drain(32'h100, 21, 0, -1, 0, 0, 1'b0);
      check("s6_recover_data0", 96'(cap_data[0]), 96'h1716151413121110);
`endif

      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
